// File: rtl/candy_pkg.sv
// candy_pkg: shared types and constants for the candy RV32I control path.
// Holds the sequencer state encoding, the fault-code values reported on
// fault_code, and the widths of the wait timer and performance counters.

package candy_pkg;

   // Width of the retired / cycles performance counters.
   localparam int CNT_W = 32;

   // Width of the memory wait counter.
   localparam int WAIT_W = 8;

   // Sequencer states, one-hot so each output decodes from a single flop.
   typedef enum logic [5:0] {
      ST_FETCH   = 6'b000001,
      ST_DECODE  = 6'b000010,
      ST_EXECUTE = 6'b000100,
      ST_MEM     = 6'b001000,
      ST_WB      = 6'b010000,
      ST_HALT    = 6'b100000
   } seq_state_t;

   // Reasons for entering HALT, as reported on fault_code.
   localparam logic [1:0] FAULT_NONE    = 2'd0;
   localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
   localparam logic [1:0] FAULT_DMEM_TO = 2'd2;
   localparam logic [1:0] FAULT_IMEM_TO = 2'd3;

   // True for the states that wait on a memory acknowledge.
   function automatic logic is_wait_state(input seq_state_t s);
      return (s == ST_FETCH) || (s == ST_MEM);
   endfunction

endpackage

// File: rtl/step_wait_timer.sv
// step_wait_timer: 8-bit saturating wait counter shared by FETCH and MEM.
// The count is cleared while 'clear' is high and otherwise advances on
// 'enable'. 'expired' is high in the cycle whose un-acked increment brings
// the count to MEM_TIMEOUT, so the owner leaves on exactly the
// MEM_TIMEOUT-th waiting cycle. An ack in that cycle still wins, because
// the owner checks the ack before 'expired'.

module step_wait_timer
   import candy_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   // Legal range is 1..255; out-of-range values are clamped.
   localparam int LIMIT_I = (MEM_TIMEOUT < 1)   ? 0   :
                            (MEM_TIMEOUT > 255) ? 254 : MEM_TIMEOUT - 1;
   localparam logic [WAIT_W-1:0] LIMIT   = WAIT_W'(LIMIT_I);
   localparam logic [WAIT_W-1:0] SAT_MAX = {WAIT_W{1'b1}};

   logic [WAIT_W-1:0] count;

   // Count waiting cycles; clear has priority and the count never wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != SAT_MAX)) begin
         count <= count + 8'd1;
      end
   end

   assign expired = (count >= LIMIT);

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: multi-cycle control FSM for the candy RV32I core.
// Walks each instruction through FETCH, DECODE, EXECUTE, optional MEM and
// WB, drives the imem/dmem request handshakes and the per-stage enables,
// and parks in HALT on ECALL/EBREAK, illegal opcodes or memory timeouts.
// All outputs decode from registered state and flags only.
// Optional feature: define SEQ_PERF_EN to add the retired/cycles counters.

module step_sequencer
   import candy_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   input  logic             is_mem,
   input  logic             is_store,
   input  logic             is_system,
   input  logic             illegal,
   input  logic             resume,
   output logic             en_decode,
   output logic             en_execute,
   output logic             en_writeback,
   output logic             halted,
   output logic             fault,
   output logic [1:0]       fault_code
`ifdef SEQ_PERF_EN
   ,
   output logic [CNT_W-1:0] retired,
   output logic [CNT_W-1:0] cycles
`endif
);

   seq_state_t state;
   logic       store_q;
   logic       sys_pending;
   logic [1:0] code_q;

   logic wait_enable;
   logic wait_clear;
   logic wait_expired;

   // The timer runs only while a wait state is still un-acked; every other
   // cycle clears it, so each FETCH or MEM entry starts from zero.
   assign wait_enable = is_wait_state(state) &&
                        (((state == ST_FETCH) && !imem_ack) ||
                         ((state == ST_MEM)   && !dmem_ack));
   assign wait_clear  = !wait_enable;

   step_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (wait_clear),
      .enable  (wait_enable),
      .expired (wait_expired)
   );

   // Main sequencer: state transitions plus the store, ECALL and fault flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_FETCH;
         store_q     <= 1'b0;
         sys_pending <= 1'b0;
         code_q      <= FAULT_NONE;
      end else begin
         unique case (state)
            ST_FETCH: begin
               if (imem_ack) begin
                  state <= ST_DECODE;
               end else if (wait_expired) begin
                  state  <= ST_HALT;
                  code_q <= FAULT_IMEM_TO;
               end
            end
            ST_DECODE: begin
               state <= ST_EXECUTE;
            end
            ST_EXECUTE: begin
               if (illegal) begin
                  state  <= ST_HALT;
                  code_q <= FAULT_ILLEGAL;
               end else if (is_system) begin
                  state       <= ST_HALT;
                  sys_pending <= 1'b1;
               end else if (is_mem) begin
                  state   <= ST_MEM;
                  store_q <= is_store;
               end else begin
                  state <= ST_WB;
               end
            end
            ST_MEM: begin
               if (dmem_ack) begin
                  state   <= ST_WB;
                  store_q <= 1'b0;
               end else if (wait_expired) begin
                  state   <= ST_HALT;
                  store_q <= 1'b0;
                  code_q  <= FAULT_DMEM_TO;
               end
            end
            ST_WB: begin
               state <= ST_FETCH;
            end
            ST_HALT: begin
               if (resume) begin
                  state       <= sys_pending ? ST_WB : ST_FETCH;
                  sys_pending <= 1'b0;
                  code_q      <= FAULT_NONE;
               end
            end
            default: begin
               state       <= ST_FETCH;
               store_q     <= 1'b0;
               sys_pending <= 1'b0;
               code_q      <= FAULT_NONE;
            end
         endcase
      end
   end

   assign imem_req     = (state == ST_FETCH);
   assign dmem_req     = (state == ST_MEM);
   assign dmem_we      = store_q;
   assign en_decode    = (state == ST_DECODE);
   assign en_execute   = (state == ST_EXECUTE);
   assign en_writeback = (state == ST_WB);
   assign halted       = (state == ST_HALT);
   assign fault_code   = code_q;
   assign fault        = (code_q != FAULT_NONE);

`ifdef SEQ_PERF_EN
   // Performance counters: instructions retired and cycles spent outside HALT.
   always_ff @(posedge clk) begin
      if (reset) begin
         retired <= '0;
         cycles  <= '0;
      end else begin
         if (state == ST_WB) begin
            retired <= retired + CNT_W'(1);
         end
         if (state != ST_HALT) begin
            cycles <= cycles + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: randomized scoreboard bench for step_sequencer.
// The stimulus side derives each instruction's timeline from its wait
// counts and decode flags, pushes the expected handshake/halt/writeback
// events, and drives the inputs open-loop. A monitor turns DUT output edges
// into events and compares them against the queue.
// Counter checks are included when SEQ_PERF_EN is defined.

`timescale 1ns/1ps

module tb_step_sequencer;
   import candy_pkg::*;

   localparam int TIMEOUT = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic imem_ack = 1'b0, dmem_ack = 1'b0;
   logic is_mem = 1'b0, is_store = 1'b0, is_system = 1'b0, illegal = 1'b0;
   logic resume = 1'b0;
   logic imem_req, dmem_req, dmem_we;
   logic en_decode, en_execute, en_writeback, halted, fault;
   logic [1:0] fault_code;
`ifdef SEQ_PERF_EN
   logic [31:0] retired, cycles;
`endif

   step_sequencer #(
      .MEM_TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_ack     (imem_ack),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_ack     (dmem_ack),
      .is_mem       (is_mem),
      .is_store     (is_store),
      .is_system    (is_system),
      .illegal      (illegal),
      .resume       (resume),
      .en_decode    (en_decode),
      .en_execute   (en_execute),
      .en_writeback (en_writeback),
      .halted       (halted),
      .fault        (fault),
      .fault_code   (fault_code)
`ifdef SEQ_PERF_EN
      ,
      .retired      (retired),
      .cycles       (cycles)
`endif
   );

   // Free-running clock and cycle stamp shared by stimulus and monitor.
   always #5 clk = ~clk;

   int tbCycle = 0;
   always @(posedge clk) tbCycle <= tbCycle + 1;

   typedef enum int {EV_IMEM = 0, EV_DMEM = 1, EV_HALT = 2, EV_WB = 3} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      int         cyc;
      int         len;
      logic       we;
      logic [1:0] code;
      int         ret;
      int         cnt;
   } ev_t;

   ev_t expQ[$];
   int  compared = 0;
   int  mismatched = 0;
   int  modelRet = 0;
   int  modelCyc = 0;
   int  expDec = 0;
   int  expExe = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, tbCycle);
      end
   endtask

   function automatic void pushEv(input ev_kind_t k, input int cyc, input int len, input logic we,
                                  input logic [1:0] code, input int ret, input int cnt);
      ev_t e;
      e.kind = k;
      e.cyc  = cyc;
      e.len  = len;
      e.we   = we;
      e.code = code;
      e.ret  = ret;
      e.cnt  = cnt;
      expQ.push_back(e);
   endfunction

   // Pop the next expected event and compare it with what the DUT showed.
   task automatic observe(input ev_kind_t kind, input int len, input logic we, input logic weVar);
      ev_t e;
      if (expQ.size() == 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, tbCycle);
         return;
      end
      e = expQ.pop_front();
      checkOutput("event_kind", kind, e.kind);
      checkOutput("event_cycle", tbCycle, e.cyc);
      case (kind)
         EV_IMEM: checkOutput("imem_req_len", len, e.len);
         EV_DMEM: begin
            checkOutput("dmem_req_len", len, e.len);
            checkOutput("dmem_we", we, e.we);
            checkOutput("dmem_we_stable", weVar, 1'b0);
         end
         EV_HALT: begin
            checkOutput("fault_code", fault_code, e.code);
            checkOutput("fault", fault, (e.code != FAULT_NONE));
`ifdef SEQ_PERF_EN
            checkOutput("halt_retired", retired, e.ret);
            checkOutput("halt_cycles", cycles, e.cnt);
`endif
         end
         default: begin
            checkOutput("wb_halted", halted, 1'b0);
`ifdef SEQ_PERF_EN
            checkOutput("wb_retired", retired, e.ret);
            checkOutput("wb_cycles", cycles, e.cnt);
`endif
         end
      endcase
   endtask

   // Monitor: turn request falls, HALT entry and writeback pulses into events.
   bit   monOn = 0;
   int   imemLen = 0, dmemLen = 0, decPulses = 0, exePulses = 0;
   logic prevImem = 1'b0, prevDmem = 1'b0, prevHalted = 1'b0;
   logic weFirst = 1'b0, weVar = 1'b0;

   always @(negedge clk) begin
      #1;
      if (monOn) begin
         if (!imem_req && prevImem) begin
            observe(EV_IMEM, imemLen, 1'b0, 1'b0);
            imemLen = 0;
         end
         if (imem_req) imemLen++;
         if (!dmem_req && prevDmem) begin
            observe(EV_DMEM, dmemLen, weFirst, weVar);
            dmemLen = 0;
            weVar = 1'b0;
         end
         if (dmem_req) begin
            if (dmemLen == 0) weFirst = dmem_we;
            else if (dmem_we !== weFirst) weVar = 1'b1;
            dmemLen++;
         end
         if (halted && !prevHalted) observe(EV_HALT, 0, 1'b0, 1'b0);
         if (en_writeback) observe(EV_WB, 0, 1'b0, 1'b0);
         if (en_decode) decPulses++;
         if (en_execute) exePulses++;
         prevImem   = imem_req;
         prevDmem   = dmem_req;
         prevHalted = halted;
      end
   end

   // Drive one cycle of inputs at a falling edge, then wait for the next one.
   task automatic stepCycle(input logic ia, input logic da, input logic [3:0] fl, input logic rs);
      imem_ack = ia;
      dmem_ack = da;
      {illegal, is_system, is_mem, is_store} = fl;
      resume = rs;
      @(negedge clk);
   endtask

   function automatic logic junk();
      return ($urandom_range(0, 3) == 0);
   endfunction

   // One instruction: iw/dw are ack delays in cycles, flags = {illegal, system, mem, store}.
   task automatic applyStimulus(input int iw, input logic [3:0] flags, input int dw, input int dwell);
      int s, fl, dl, e1, haltAt, wbAt, endAt, haltCycles;
      logic sysHalt, memPath;
      logic [1:0] code;
      logic ia, da, rs;
      logic [3:0] f;
      s = tbCycle;
      haltAt = -1;
      wbAt = -1;
      e1 = -1;
      dl = 0;
      sysHalt = 1'b0;
      memPath = 1'b0;
      code = FAULT_NONE;
      fl = (iw < TIMEOUT) ? iw + 1 : TIMEOUT;
      pushEv(EV_IMEM, s + fl, fl, 1'b0, FAULT_NONE, 0, 0);
      if (iw >= TIMEOUT) begin
         haltAt = s + TIMEOUT;
         code = FAULT_IMEM_TO;
      end else begin
         expDec++;
         expExe++;
         e1 = s + fl + 2;
         if (flags[3]) begin
            haltAt = e1;
            code = FAULT_ILLEGAL;
         end else if (flags[2]) begin
            haltAt = e1;
            sysHalt = 1'b1;
         end else if (flags[1]) begin
            memPath = 1'b1;
            dl = (dw < TIMEOUT) ? dw + 1 : TIMEOUT;
            pushEv(EV_DMEM, e1 + dl, dl, flags[0], FAULT_NONE, 0, 0);
            if (dw >= TIMEOUT) begin
               haltAt = e1 + TIMEOUT;
               code = FAULT_DMEM_TO;
            end else begin
               wbAt = e1 + dl;
            end
         end else begin
            wbAt = e1;
         end
      end
      if (haltAt >= 0) begin
         pushEv(EV_HALT, haltAt, 0, 1'b0, code, modelRet, modelCyc + (haltAt - s));
         if (sysHalt) wbAt = haltAt + dwell + 1;
         endAt = haltAt + dwell + 1 + (sysHalt ? 1 : 0);
         haltCycles = dwell + 1;
      end else begin
         endAt = wbAt + 1;
         haltCycles = 0;
      end
      if (wbAt >= 0)
         pushEv(EV_WB, wbAt, 0, 1'b0, FAULT_NONE, modelRet,
                sysHalt ? modelCyc + (haltAt - s) : modelCyc + (wbAt - s));

      for (int c = s; c <= endAt; c++) begin
         if (haltAt >= 0 && c == haltAt + dwell + 1) begin
            checkOutput("resume_halted", halted, 1'b0);
            checkOutput("resume_fault", fault, 1'b0);
            checkOutput("resume_code", fault_code, FAULT_NONE);
         end
         if (c == endAt) break;
         ia = junk();
         da = junk();
         rs = junk();
         f  = 4'($urandom);
         if (c >= s && c < s + fl) ia = (c == s + iw);
         if (e1 >= 0 && c == e1 - 1) f = flags;
         if (memPath && c >= e1 && c < e1 + dl) da = (c == e1 + dw);
         if (haltAt >= 0 && c >= haltAt && c <= haltAt + dwell) rs = (c == haltAt + dwell);
         stepCycle(ia, da, f, rs);
      end
      modelCyc += (endAt - s) - haltCycles;
      if (wbAt >= 0) modelRet++;
   endtask

   // Reset lands in the second MEM cycle together with dmem_ack.
   task automatic resetMidMem();
      int s;
      s = tbCycle;
      pushEv(EV_IMEM, s + 1, 1, 1'b0, FAULT_NONE, 0, 0);
      pushEv(EV_DMEM, s + 5, 2, 1'b0, FAULT_NONE, 0, 0);
      expDec++;
      expExe++;
      stepCycle(1'b1, 1'b0, 4'b0000, 1'b0);
      stepCycle(1'b0, 1'b0, 4'b0000, 1'b0);
      stepCycle(1'b0, 1'b0, 4'b0010, 1'b0);
      stepCycle(1'b0, 1'b0, 4'b0000, 1'b0);
      reset = 1'b1;
      stepCycle(1'b0, 1'b1, 4'b0000, 1'b0);
      reset = 1'b0;
      checkOutput("rst_imem_req", imem_req, 1'b1);
      checkOutput("rst_dmem_req", dmem_req, 1'b0);
      checkOutput("rst_en_writeback", en_writeback, 1'b0);
      checkOutput("rst_halted", halted, 1'b0);
`ifdef SEQ_PERF_EN
      checkOutput("rst_retired", retired, 0);
      checkOutput("rst_cycles", cycles, 0);
`endif
      modelCyc = 0;
      modelRet = 0;
   endtask

   // Main sequence: reset checks, directed cases, random mix, mid-op reset.
   initial begin
      int iw, dw, dwell;
      logic [3:0] flags;
      repeat (3) @(negedge clk);
      checkOutput("reset_imem_req", imem_req, 1'b1);
      checkOutput("reset_dmem_req", dmem_req, 1'b0);
      checkOutput("reset_dmem_we", dmem_we, 1'b0);
      checkOutput("reset_enables", {en_decode, en_execute, en_writeback}, 3'b000);
      checkOutput("reset_halted", halted, 1'b0);
      checkOutput("reset_fault", {fault, fault_code}, 3'b000);
`ifdef SEQ_PERF_EN
      checkOutput("reset_retired", retired, 0);
      checkOutput("reset_cycles", cycles, 0);
`endif
      reset = 1'b0;
      monOn = 1;

      applyStimulus(0, 4'b0000, 0, 0);
      applyStimulus(0, 4'b0010, 3, 0);
      applyStimulus(0, 4'b0011, 9, 2);
      applyStimulus(1, 4'b1100, 0, 3);
      applyStimulus(0, 4'b0100, 0, 10);
      applyStimulus(3, 4'b0000, 0, 0);
      applyStimulus(7, 4'b0000, 0, 1);
      applyStimulus(0, 4'b0010, 4, 0);
      applyStimulus(2, 4'b0011, 2, 0);

      for (int n = 0; n < 60; n++) begin
         iw    = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
         dw    = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
         flags = {($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
         dwell = $urandom_range(0, 4);
         applyStimulus(iw, flags, dw, dwell);
      end

      resetMidMem();
      applyStimulus(0, 4'b0000, 0, 0);

      #2;
      checkOutput("scoreboard_drained", expQ.size(), 0);
      checkOutput("decode_pulses", decPulses, expDec);
      checkOutput("execute_pulses", exePulses, expExe);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
